// File: rtl/mux_pkg.sv
// Shared constants and FSM encoding for the registered operand selector.
package mux_pkg;

    // Default datapath geometry
    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_SEL_W = 3;

    // Named channel slots used by the datapath
    localparam int unsigned IDX_CONST4 = 1;  // PC+4 increment slot
    localparam int unsigned CONST4_VAL = 4;

    // Selector FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SWEEP = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/mux_n_comb.sv
// Combinational N-way channel select with optional constant slot and
// fallback to a default channel for out-of-range selectors.
module mux_n_comb #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned N_IN        = 5,
    parameter int unsigned SEL_W       = 3,
    parameter bit          CONST_EN    = 1'b1,
    parameter int unsigned CONST_IDX   = 1,
    parameter int unsigned CONST_VAL   = 4,
    parameter int unsigned DEFAULT_IDX = 0
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_IN*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]      data,
    output logic [SEL_W-1:0]      idx,
    output logic                  out_of_range
);

    // Resolve the effective index, then pick that channel (or the constant)
    always_comb begin
        idx          = sel;
        out_of_range = 1'b0;
        if (32'(sel) >= N_IN) begin
            idx          = SEL_W'(DEFAULT_IDX);
            out_of_range = 1'b1;
        end
        data = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (idx == SEL_W'(k)) begin
                if (CONST_EN && (k == CONST_IDX)) begin
                    data = WIDTH'(CONST_VAL);
                end else begin
                    data = data_in[k*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/mux_sel_reg.sv
// Registered N-way operand selector with sticky range error and a debug
// sweep mode that streams every channel out on successive cycles.
module mux_sel_reg
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned N_IN        = 5,
    parameter int unsigned SEL_W       = DEF_SEL_W,
    parameter bit          CONST_EN    = 1'b1,
    parameter int unsigned CONST_IDX   = IDX_CONST4,
    parameter int unsigned CONST_VAL   = CONST4_VAL,
    parameter int unsigned DEFAULT_IDX = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [SEL_W-1:0]      selector,
    input  logic [N_IN*WIDTH-1:0] data_in,
    input  logic                  sweep_start,
    input  logic                  err_clr,
    output logic [WIDTH-1:0]      data_out,
    output logic                  out_valid,
    output logic [SEL_W-1:0]      out_idx,
    output logic                  sel_err,
    output logic                  sweep_busy,
    output logic                  sweep_done
);

    if (N_IN < 2 || N_IN > (1 << SEL_W) || CONST_IDX >= N_IN || DEFAULT_IDX >= N_IN)
    begin : g_param_check
        $fatal(1, "mux_sel_reg: illegal N_IN/SEL_W/CONST_IDX/DEFAULT_IDX combination");
    end

    state_t           state_q;
    logic [SEL_W-1:0] cnt_q;

    logic [WIDTH-1:0] load_data;
    logic [SEL_W-1:0] load_idx;
    logic             load_oor;
    logic [WIDTH-1:0] sweep_data;
    logic [SEL_W-1:0] sweep_idx;
    logic             sweep_oor_unused;  // counter never leaves 0..N_IN-1

    logic start_accept;
    logic load_accept;
    logic last_emit;

    // Sweep start wins over a same-cycle load; loads outside IDLE are dropped
    assign start_accept = (state_q == ST_IDLE) && sweep_start;
    assign load_accept  = (state_q == ST_IDLE) && load && !sweep_start;
    assign last_emit    = (state_q == ST_SWEEP) && (cnt_q == SEL_W'(N_IN - 1));

    mux_n_comb #(
        .WIDTH       (WIDTH),
        .N_IN        (N_IN),
        .SEL_W       (SEL_W),
        .CONST_EN    (CONST_EN),
        .CONST_IDX   (CONST_IDX),
        .CONST_VAL   (CONST_VAL),
        .DEFAULT_IDX (DEFAULT_IDX)
    ) u_load_mux (
        .sel          (selector),
        .data_in      (data_in),
        .data         (load_data),
        .idx          (load_idx),
        .out_of_range (load_oor)
    );

    mux_n_comb #(
        .WIDTH       (WIDTH),
        .N_IN        (N_IN),
        .SEL_W       (SEL_W),
        .CONST_EN    (CONST_EN),
        .CONST_IDX   (CONST_IDX),
        .CONST_VAL   (CONST_VAL),
        .DEFAULT_IDX (DEFAULT_IDX)
    ) u_sweep_mux (
        .sel          (cnt_q),
        .data_in      (data_in),
        .data         (sweep_data),
        .idx          (sweep_idx),
        .out_of_range (sweep_oor_unused)
    );

    // FSM, sweep counter and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            data_out   <= '0;
            out_idx    <= '0;
            out_valid  <= 1'b0;
            sweep_busy <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sweep_done <= 1'b0;
                    out_valid  <= load_accept;
                    if (start_accept) begin
                        state_q    <= ST_SWEEP;
                        cnt_q      <= '0;
                        sweep_busy <= 1'b1;
                    end else if (load_accept) begin
                        data_out <= load_data;
                        out_idx  <= load_idx;
                    end
                end
                ST_SWEEP: begin
                    data_out  <= sweep_data;
                    out_idx   <= sweep_idx;
                    out_valid <= 1'b1;
                    if (last_emit) begin
                        state_q <= ST_DONE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + SEL_W'(1);
                    end
                end
                ST_DONE: begin
                    out_valid  <= 1'b0;
                    sweep_busy <= 1'b0;
                    sweep_done <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    cnt_q      <= '0;
                    out_valid  <= 1'b0;
                    sweep_busy <= 1'b0;
                    sweep_done <= 1'b0;
                end
            endcase
        end
    end

    // Sticky range error: a bad accepted load beats a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_err <= 1'b0;
        end else if (load_accept && load_oor) begin
            sel_err <= 1'b1;
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end

endmodule
